// File: rtl/data_mem_ctrl.sv
// Byte-addressed data memory with a req/done handshake, programmable wait states,
// sized/extended loads and misaligned-access rejection. Optional macro: DATA_MEM_ERR_CNT_EN.
module data_mem_ctrl #(
  parameter int IO_BUS_SIZE   = 32,
  parameter int MEM_ADDR_SIZE = 5,
  parameter int WAIT_STATES   = 2
) (
  input  logic                                    i_clk,
  input  logic                                    i_reset,
  input  logic                                    i_req,
  input  logic                                    i_mem_wr_rd,
  input  logic [1:0]                              i_mem_wr_src,
  input  logic [2:0]                              i_mem_rd_src,
  input  logic [IO_BUS_SIZE-1:0]                  i_addr,
  input  logic [IO_BUS_SIZE-1:0]                  i_wr_data,
  output logic [IO_BUS_SIZE-1:0]                  o_mem_rd,
  output logic                                    o_busy,
  output logic                                    o_done,
  output logic                                    o_misaligned,
  output logic [(2**MEM_ADDR_SIZE)*IO_BUS_SIZE-1:0] o_bus_debug
`ifdef DATA_MEM_ERR_CNT_EN
  ,
  output logic [7:0]                              o_err_count
`endif
);

  localparam int LANE_BITS = $clog2(IO_BUS_SIZE / 8);
  localparam int DEPTH     = 2 ** MEM_ADDR_SIZE;
  localparam int ADDR_BITS = MEM_ADDR_SIZE + LANE_BITS;
  localparam logic [IO_BUS_SIZE-1:0] BYTE_MASK = {{(IO_BUS_SIZE-8){1'b0}}, 8'hFF};
  localparam logic [IO_BUS_SIZE-1:0] HALF_MASK = {{(IO_BUS_SIZE-16){1'b0}}, 16'hFFFF};

  if (!(IO_BUS_SIZE == 32 || IO_BUS_SIZE == 64)) begin : g_bad_bus_size
    $error("data_mem_ctrl: IO_BUS_SIZE must be 32 or 64");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
    $error("data_mem_ctrl: WAIT_STATES must be in 0..15");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                   state, next_state;
  logic [3:0]               wait_cnt;
  logic [ADDR_BITS-1:0]     addr_q;
  logic [IO_BUS_SIZE-1:0]   wr_data_q;
  logic [1:0]               wr_src_q;
  logic [2:0]               rd_src_q;
  logic                     wr_rd_q;
  logic                     mis_q;
  logic [IO_BUS_SIZE-1:0]   mem [DEPTH];

  logic                     req_is_half, req_is_full, req_mis;
  logic [MEM_ADDR_SIZE-1:0] word_idx;
  logic [LANE_BITS+2:0]     shift;
  logic [IO_BUS_SIZE-1:0]   cur_word, shifted, store_mask, new_word, load_val;
  logic                     unused_addr_bits;

  assign unused_addr_bits = ^i_addr[IO_BUS_SIZE-1:ADDR_BITS];

  // Byte accesses can never be misaligned; 3 on wr_src and 5..7 on rd_src mean full bus.
  assign req_is_half = i_mem_wr_rd ? (i_mem_wr_src == 2'd1) : (i_mem_rd_src[2:1] == 2'b01);
  assign req_is_full = i_mem_wr_rd ? i_mem_wr_src[1] : i_mem_rd_src[2];
  assign req_mis     = (req_is_half && i_addr[0]) ||
                       (req_is_full && (i_addr[LANE_BITS-1:0] != '0));

  assign word_idx = addr_q[ADDR_BITS-1:LANE_BITS];
  assign shift    = {addr_q[LANE_BITS-1:0], 3'b000};
  assign cur_word = mem[word_idx];
  assign shifted  = cur_word >> shift;

  always_comb begin
    store_mask = '1;
    case (wr_src_q)
      2'd0:    store_mask = BYTE_MASK << shift;
      2'd1:    store_mask = HALF_MASK << shift;
      default: store_mask = '1;
    endcase
  end

  assign new_word = (cur_word & ~store_mask) | ((wr_data_q << shift) & store_mask);

  always_comb begin
    load_val = cur_word;
    case (rd_src_q)
      3'd0:    load_val = {{(IO_BUS_SIZE-8){shifted[7]}}, shifted[7:0]};
      3'd1:    load_val = {{(IO_BUS_SIZE-8){1'b0}}, shifted[7:0]};
      3'd2:    load_val = {{(IO_BUS_SIZE-16){shifted[15]}}, shifted[15:0]};
      3'd3:    load_val = {{(IO_BUS_SIZE-16){1'b0}}, shifted[15:0]};
      default: load_val = cur_word;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= next_state;
  end

  // Misaligned requests bypass ACCESS entirely so nothing is written or loaded.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (i_req) next_state = req_mis ? DONE : ACCESS;
      ACCESS:  if (wait_cnt == 4'd0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wait_cnt  <= '0;
      addr_q    <= '0;
      wr_data_q <= '0;
      wr_src_q  <= '0;
      rd_src_q  <= '0;
      wr_rd_q   <= 1'b0;
      mis_q     <= 1'b0;
      o_mem_rd  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req) begin
            addr_q    <= i_addr[ADDR_BITS-1:0];
            wr_data_q <= i_wr_data;
            wr_src_q  <= i_mem_wr_src;
            rd_src_q  <= i_mem_rd_src;
            wr_rd_q   <= i_mem_wr_rd;
            mis_q     <= req_mis;
            wait_cnt  <= 4'(WAIT_STATES);
          end
        end
        ACCESS: begin
          if (wait_cnt == 4'd0) begin
            if (wr_rd_q) mem[word_idx] <= new_word;
            else         o_mem_rd      <= load_val;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy       = (state != IDLE);
  assign o_done       = (state == DONE);
  assign o_misaligned = (state == DONE) && mis_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_debug
    assign o_bus_debug[g*IO_BUS_SIZE +: IO_BUS_SIZE] = mem[g];
  end

`ifdef DATA_MEM_ERR_CNT_EN
  always_ff @(posedge i_clk) begin
    if (i_reset)                                              o_err_count <= 8'd0;
    else if (state == DONE && mis_q && o_err_count != 8'hFF)  o_err_count <= o_err_count + 8'd1;
  end
`endif

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Parametrised successor to the pipeline data memory. It is byte-addressed, with configurable bus width and depth, and supports byte/half/full-bus stores and sign- or zero-extended loads. Each access runs through a req/done handshake with a configurable number of wait states, and misaligned accesses are detected and reported. It sits in the MEM stage, with the stall unit consuming o_busy. The full contents are exported on a debug bus for the debug unit.

Parameters:
- IO_BUS_SIZE, 32: data and address width in bits. Legal values are 32 or 64; any other value is an elaboration error.
- MEM_ADDR_SIZE, 5: log2 of the number of IO_BUS_SIZE-wide words.
- WAIT_STATES, 2: extra access cycles, range 0..15.
- LANE_BITS, derived, equals $clog2(IO_BUS_SIZE/8): byte-offset bits in the address.

Ports:
- i_clk, in, 1: clock, rising edge.
- i_reset, in, 1: synchronous, active-high reset.
- i_req, in, 1: access request, sampled only in IDLE.
- i_mem_wr_rd, in, 1: 1 = write, 0 = read.
- i_mem_wr_src, in, 2: store size. 0 = byte, 1 = half, 2 = full bus; 3 is treated as full bus.
- i_mem_rd_src, in, 3: load mode. 0 = signed byte, 1 = unsigned byte, 2 = signed half, 3 = unsigned half, 4 = full bus; 5..7 are treated as full bus.
- i_addr, in, IO_BUS_SIZE: byte address.
- i_wr_data, in, IO_BUS_SIZE: store data, right-aligned.
- o_mem_rd, out, IO_BUS_SIZE: extended load result.
- o_busy, out, 1: access in flight.
- o_done, out, 1: one-cycle completion pulse.
- o_misaligned, out, 1: qualifies o_done; the access was rejected.
- o_bus_debug, out, 2**MEM_ADDR_SIZE*IO_BUS_SIZE: word i is at [i*IO_BUS_SIZE +: IO_BUS_SIZE].

Behaviour:
- Reset (synchronous, active-high):
  - All memory words are cleared to 0 and the FSM goes to IDLE.
  - o_mem_rd = 0, o_busy = 0, o_done = 0, o_misaligned = 0.
  - Reset mid-access aborts the access with no write and no o_done.
- FSM states are IDLE, ACCESS and DONE.
  - IDLE: if i_req = 1, latch the address, data, size/mode and direction, then go to ACCESS. The wait counter loads WAIT_STATES.
  - ACCESS: stays for WAIT_STATES+1 cycles. On the final ACCESS edge the store commits or the load result is registered into o_mem_rd; then go to DONE.
  - DONE: o_done = 1 for exactly one cycle, then go to IDLE.
- Misaligned requests (half with addr[0] = 1; full bus with addr[LANE_BITS-1:0] != 0) skip ACCESS and go IDLE -> DONE. In DONE, o_misaligned = 1, there is no memory write, and o_mem_rd is unchanged. o_misaligned is 0 whenever o_done is 0.
- Latency:
  - A request sampled at edge 0 gives o_done high in the cycle after edge WAIT_STATES+1.
  - For a misaligned request, o_done is high in the cycle after edge 0.
- o_busy is 1 in ACCESS and DONE. i_req is ignored while o_busy = 1. A new request is accepted the cycle after DONE.
- Addressing:
  - Word index = latched addr[MEM_ADDR_SIZE+LANE_BITS-1 : LANE_BITS]; upper bits are ignored, so addresses wrap.
  - Lane = addr[LANE_BITS-1:0].
- Stores:
  - A byte store writes i_wr_data[7:0] into the selected byte lane.
  - A half store writes i_wr_data[15:0] into lanes {lane+1, lane}.
  - Other lanes are preserved (read-modify-write within the commit edge).
- Loads:
  - The selected byte or half is right-aligned, then sign- or zero-extended to IO_BUS_SIZE.
  - o_mem_rd holds the last load result until the next successful load completes. Writes never change it.
- o_bus_debug is a combinational view of the memory array; a committed store is visible the cycle after the commit edge.

Optional Feature:
- Macro: DATA_MEM_ERR_CNT_EN.
- Defined:
  - Adds output port o_err_count (8 bits), an unsigned saturating count of misaligned accesses.
  - It increments in the DONE cycle when o_misaligned = 1 and holds at 255.
  - Reset sets it to 0.
- Undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
Each line is stimulus -> required response. All scenarios use IO_BUS_SIZE=32, MEM_ADDR_SIZE=5, WAIT_STATES=2.
1. Release reset; write word 0xDEADBEEF to addr 0x08, then read word from 0x08 -> o_done high exactly 3 cycles after the req-sampling edge; o_mem_rd = 0xDEADBEEF; debug word 2 = 0xDEADBEEF; other debug words = 0.
2. Byte store 0x000000A5 to addr 0x0D -> debug word 3 = 0x0000A500. Signed-byte load from 0x0D -> o_mem_rd = 0xFFFFFFA5. Unsigned-byte load -> 0x000000A5.
3. Half store 0x00008001 to addr 0x12 -> debug word 4 = 0x80010000. Signed-half load -> 0xFFFF8001. Unsigned-half load -> 0x00008001.
4. Word read at misaligned addr 0x06 -> o_done and o_misaligned high 1 cycle after the sampling edge; o_mem_rd keeps its previous value; memory unchanged; o_err_count = 1 if DATA_MEM_ERR_CNT_EN is defined.
5. Two requests:
   - Hold i_req = 1 continuously with a word write of 0x11111111 to 0x00, changing the data to 0x22222222 while busy -> word 0 = 0x11111111; second request accepted only after DONE.
   - Write 0x33333333 to 0x04, then assert i_reset in its 2nd ACCESS cycle -> word 1 = 0, no o_done, o_busy = 0 the next cycle.
6. Word write 0xCAFEF00D to addr 0x80, then read from 0x00 -> o_mem_rd = 0xCAFEF00D (address wrap).
